// File: rtl/prio_encoder_rr_pkg.sv
// prio_pkg: shared constants and helpers for the registered priority encoder.
//   MODE_FIXED / MODE_RR : values of the MODE parameter of prio_encoder_rr
//   next_idx(idx, n)     : index after idx in a ring of n entries (n-1 wraps to 0)
package prio_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    // Ring successor; works for any n >= 1, not only powers of two.
    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
        if (idx + 32'd1 >= n) begin
            return 32'd0;
        end else begin
            return idx + 32'd1;
        end
    endfunction

endpackage

// File: rtl/prio_encoder_rr_pick.sv
// prio_pick: combinational lowest-set-index search starting at a base index.
//   req  [N-1:0] : request vector
//   base [W-1:0] : first index eligible in the masked search
//   idx  [W-1:0] : lowest set index >= base, else lowest set index overall
//   any          : at least one request is set
module prio_pick #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] base,
    output logic [W-1:0] idx,
    output logic         any
);

    logic [N-1:0] mask_s;
    logic [N-1:0] req_m_s;
    logic [W-1:0] idx_u_s;
    logic [W-1:0] idx_m_s;
    logic         hit_m_s;

    // Thermometer mask keeping only indices at or above base.
    always_comb begin
        mask_s = '0;
        for (int i = 0; i < N; i++) begin
            mask_s[i] = (W'(i) >= base);
        end
    end

    assign req_m_s = req & mask_s;

    // Two lowest-set searches: scanning downward lets the lowest hit win.
    always_comb begin
        idx_u_s = '0;
        idx_m_s = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx_u_s = req[i]     ? W'(i) : idx_u_s;
            idx_m_s = req_m_s[i] ? W'(i) : idx_m_s;
        end
    end

    assign hit_m_s = |req_m_s;
    assign any     = |req;
    // Masked search wins; otherwise wrap around to the lowest request overall.
    assign idx     = hit_m_s ? idx_m_s : idx_u_s;

endmodule

// File: rtl/prio_encoder_rr.sv
// prio_encoder_rr: registered priority encoder with valid/ready output and
// fixed-priority (MODE=0) or round-robin (MODE=1) arbitration.
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   din [N-1:0]     : level request vector
//   out_ready       : consumer takes the held result this cycle
//   out_valid       : code/grant hold a result
//   code [W-1:0]    : winning index
//   grant [N-1:0]   : one-hot of code, zero when not valid
//   pending         : combinational OR of din
module prio_encoder_rr
    import prio_pkg::*;
#(
    parameter int N    = 8,
    parameter int W    = $clog2(N),
    parameter int MODE = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] din,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] code,
    output logic [N-1:0] grant,
    output logic         pending
);

    localparam logic [N-1:0] GRANT_ONE = {{(N - 1){1'b0}}, 1'b1};

    logic         out_valid_r;
    logic [W-1:0] code_r;
    logic [N-1:0] grant_r;
    logic [W-1:0] ptr_r;

    logic         load_s;
    logic         accept_s;
    logic [W-1:0] next_ptr_s;
    logic [W-1:0] base_s;
    logic [W-1:0] idx_s;
    logic         any_s;

    assign load_s     = !out_valid_r || out_ready;
    assign accept_s   = out_valid_r && out_ready;
    assign next_ptr_s = W'(next_idx(32'(code_r), 32'(N)));

    // Search base: on an accept edge the reload already sees the advanced pointer.
    always_comb begin
        base_s = '0;
        if (MODE == MODE_RR) begin
            base_s = accept_s ? next_ptr_s : ptr_r;
        end else begin
            base_s = '0;
        end
    end

    prio_pick #(
        .N (N),
        .W (W)
    ) u_pick (
        .req  (din),
        .base (base_s),
        .idx  (idx_s),
        .any  (any_s)
    );

    // Output register and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            code_r      <= '0;
            grant_r     <= '0;
            ptr_r       <= '0;
        end else begin
            if (accept_s && (MODE == MODE_RR)) begin
                ptr_r <= next_ptr_s;
            end else begin
                ptr_r <= ptr_r;
            end
            if (load_s) begin
                if (any_s) begin
                    out_valid_r <= 1'b1;
                    code_r      <= idx_s;
                    grant_r     <= GRANT_ONE << idx_s;
                end else begin
                    // code keeps its last value; only valid and grant clear.
                    out_valid_r <= 1'b0;
                    grant_r     <= '0;
                end
            end else begin
                out_valid_r <= out_valid_r;
                code_r      <= code_r;
                grant_r     <= grant_r;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign code      = code_r;
    assign grant     = grant_r;
    assign pending   = |din;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Scoreboard bench: stimulus pushes hand-computed expected codes, per-instance
// monitors pop and compare on every transfer (out_valid && out_ready).
module tb_prio_encoder_rr;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // Instance A: N=8 fixed; B: N=8 round-robin; C: N=5 round-robin.
    logic [7:0] din_a, grant_a, din_b, grant_b;
    logic [4:0] din_c, grant_c;
    logic [2:0] code_a, code_b, code_c;
    logic rdy_a, rdy_b, rdy_c, val_a, val_b, val_c, pend_a, pend_b, pend_c;

    prio_encoder_rr #(.N(8), .MODE(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .din(din_a), .out_ready(rdy_a),
        .out_valid(val_a), .code(code_a), .grant(grant_a), .pending(pend_a));
    prio_encoder_rr #(.N(8), .MODE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .din(din_b), .out_ready(rdy_b),
        .out_valid(val_b), .code(code_b), .grant(grant_b), .pending(pend_b));
    prio_encoder_rr #(.N(5), .MODE(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .din(din_c), .out_ready(rdy_c),
        .out_valid(val_c), .code(code_c), .grant(grant_c), .pending(pend_c));

    int tests = 0;
    int fails = 0;
    int exp_a[$];
    int exp_b[$];
    int exp_c[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor A.
    always @(negedge clk) begin
        if (rst_n && val_a && rdy_a) begin
            if (exp_a.size() == 0) begin
                chk("a_unexpected_xfer", 64'(code_a), 64'hFFFF);
            end else begin
                int e;
                e = exp_a.pop_front();
                chk("a_code", 64'(code_a), 64'(e));
                chk("a_grant", 64'(grant_a), 64'(8'd1 << e));
            end
        end
    end

    // Monitor B.
    always @(negedge clk) begin
        if (rst_n && val_b && rdy_b) begin
            if (exp_b.size() == 0) begin
                chk("b_unexpected_xfer", 64'(code_b), 64'hFFFF);
            end else begin
                int e;
                e = exp_b.pop_front();
                chk("b_code", 64'(code_b), 64'(e));
                chk("b_grant", 64'(grant_b), 64'(8'd1 << e));
            end
        end
    end

    // Monitor C, including the no-code-above-4 range check.
    always @(negedge clk) begin
        if (rst_n && val_c && rdy_c) begin
            chk("c_code_range", 64'(code_c < 3'd5), 64'd1);
            if (exp_c.size() == 0) begin
                chk("c_unexpected_xfer", 64'(code_c), 64'hFFFF);
            end else begin
                int e;
                e = exp_c.pop_front();
                chk("c_code", 64'(code_c), 64'(e));
                chk("c_grant", 64'(grant_c), 64'(5'd1 << e));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        din_a = 8'h00; din_b = 8'h00; din_c = 5'h00;
        rdy_a = 1'b0;  rdy_b = 1'b0;  rdy_c = 1'b0;
        step();
        step();
        chk("rst_valid", 64'({val_a, val_b, val_c}), 64'd0);
        chk("rst_code", 64'({code_a, code_b, code_c}), 64'd0);
        chk("rst_grant", 64'({grant_a, grant_b, grant_c}), 64'd0);
        rst_n = 1'b1;

        // Idle: all-zero din never produces a result.
        rdy_a = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_valid", 64'(val_a), 64'd0);
            chk("idle_pending", 64'(pend_a), 64'd0);
            chk("idle_code", 64'(code_a), 64'd0);
        end

        // Fixed: lowest set bit of 1010_0100 is 2.
        exp_a.push_back(2);
        din_a = 8'hA4;
        chk("pending_comb", 64'(pend_a), 64'd1);
        step();
        din_a = 8'h00;
        step();
        chk("empty_valid", 64'(val_a), 64'd0);
        chk("empty_grant", 64'(grant_a), 64'd0);
        chk("empty_code_held", 64'(code_a), 64'd2);

        // Backpressure: code 3 frozen while din changes to 8'h01.
        rdy_a = 1'b0;
        din_a = 8'h08;
        step();
        din_a = 8'h01;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", 64'(val_a), 64'd1);
            chk("bp_code", 64'(code_a), 64'd3);
        end
        exp_a.push_back(3);
        exp_a.push_back(0);
        rdy_a = 1'b1;
        step();
        chk("bp_release_code", 64'(code_a), 64'd0);
        din_a = 8'h00;
        step();
        rdy_a = 1'b0;

        // Round-robin N=8: FF gives 0..7,0 then 81 alternates 7,0,7,0.
        for (int i = 0; i < 8; i++) exp_b.push_back(i);
        exp_b.push_back(0);
        exp_b.push_back(7);
        exp_b.push_back(0);
        exp_b.push_back(7);
        exp_b.push_back(0);
        din_b = 8'hFF;
        rdy_b = 1'b1;
        for (int i = 0; i < 9; i++) step();
        din_b = 8'h81;
        for (int i = 0; i < 4; i++) step();
        din_b = 8'h00;
        step();
        chk("rr_b_idle_valid", 64'(val_b), 64'd0);

        // Round-robin N=5: serving 4 wraps the pointer to 0.
        exp_c.push_back(4);
        exp_c.push_back(0);
        din_c = 5'b10000;
        rdy_c = 1'b1;
        step();
        din_c = 5'b10001;
        step();
        din_c = 5'b00000;
        step();
        chk("rr_c_idle_valid", 64'(val_c), 64'd0);
        // Pointer is now 1: all-ones yields 1,2,3,4,0,1.
        exp_c.push_back(1);
        exp_c.push_back(2);
        exp_c.push_back(3);
        exp_c.push_back(4);
        exp_c.push_back(0);
        exp_c.push_back(1);
        din_c = 5'b11111;
        for (int i = 0; i < 6; i++) step();
        din_c = 5'b00000;
        step();
        rdy_c = 1'b0;

        // Reset mid-FULL on B (pointer currently 1): outputs clear at once.
        rdy_b = 1'b0;
        din_b = 8'hFF;
        step();
        chk("pre_rst_valid", 64'(val_b), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(val_b), 64'd0);
        chk("midrst_code", 64'(code_b), 64'd0);
        chk("midrst_grant", 64'(grant_b), 64'd0);
        step();
        rst_n = 1'b1;
        // Pointer was cleared, so the first round-robin pick is 0 again.
        exp_b.push_back(0);
        rdy_b = 1'b1;
        step();
        din_b = 8'h00;
        step();
        rdy_b = 1'b0;
        step();

        chk("a_queue_drained", 64'(exp_a.size()), 64'd0);
        chk("b_queue_drained", 64'(exp_b.size()), 64'd0);
        chk("c_queue_drained", 64'(exp_c.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
